// File: rtl/pc_pkg.sv
// pc_pkg: definitions shared by the program counter, the fetch unit and the
// return-address stack.
//   ADDR_W    : program-counter / address width in bits
//   addr_t    : address type (logic [ADDR_W-1:0])
//   RAS_DEPTH : default number of return-address stack entries
package pc_pkg;

  localparam int ADDR_W    = 16;
  localparam int RAS_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ras_regfile.sv
// ras_regfile: DEPTH x WIDTH register array for the return-address stack.
// It has one synchronous write port and one combinational read port. The
// storage is not reset because stack contents are don't-care until pushed.
// Ports:
//   clk   in  clock, write on rising edge
//   we    in  write enable
//   waddr in  write index
//   wdata in  write data
//   raddr in  read index
//   rdata out entry at raddr (combinational)
module ras_regfile #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // DEPTH is a power of two, so every raddr value selects a real entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: hardware return-address stack beside the program counter.
// A call pushes PC+1. A return pops, and tos_addr feeds the PC parallel-load
// input in the same cycle.
// Configuration macro: RSTACK_WRAP_EN. When it is defined, a push while full
// overwrites the oldest entry in circular order. Otherwise that push is
// rejected. Either way, overflow is set.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   push       call: store push_addr on top
//   pop        return: drop top entry (push+pop together replaces top)
//   push_addr  return address to save
//   clr_err    clear sticky flags (a new error in the same cycle wins)
//   tos_addr   top-of-stack value, 0 when empty
//   tos_valid  stack non-empty
//   full       count == DEPTH
//   count      number of valid entries
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int  WIDTH = ADDR_W,
  parameter int  DEPTH = RAS_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos_addr,
  output logic             tos_valid,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_empty;
  logic             is_full;
  logic             ovf_evt;
  logic             unf_evt;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] rd_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  // ptr points at the next free slot, so the top entry sits just below it.
  assign top_idx  = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    if (push && pop && !is_empty) begin
      // Replace the top entry. Depth is unchanged.
      wr_en   = 1'b1;
      wr_addr = top_idx;
    end else if (push) begin
      // This branch also covers push+pop on an empty stack, which acts as a
      // plain push and does not raise underflow.
      if (!is_full) begin
        wr_en   = 1'b1;
        ptr_d   = ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_evt = 1'b1;
`ifdef RSTACK_WRAP_EN
        // When full, ptr equals the oldest slot. Overwrite it and advance.
        wr_en   = 1'b1;
        ptr_d   = ptr_q + PTR_W'(1);
`else
        wr_en   = 1'b0;
`endif
      end
    end else if (pop) begin
      if (!is_empty) begin
        ptr_d   = top_idx;
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_evt = 1'b1;
      end
    end

    // Set wins over clear.
    overflow_d  = (overflow_q  & ~clr_err) | ovf_evt;
    underflow_d = (underflow_q & ~clr_err) | unf_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ras_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk  (clk),
    .we   (wr_en & ~rst),
    .waddr(wr_addr),
    .wdata(push_addr),
    .raddr(top_idx),
    .rdata(rd_data)
  );

  assign tos_addr  = is_empty ? '0 : rd_data;
  assign tos_valid = ~is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
